inert_reader: RTL

INERT_READER -- requirements
Module: inert_reader

---
 rtl/inert_pkg.sv | 20 ++
 rtl/inert_reader.sv | 116 +++++++++++
 2 files changed

// File: rtl/inert_pkg.sv
// rtl/inert_pkg.sv - shared FSM state encoding and SPI command words for the inertial reader
package inert_pkg;

    typedef enum logic [2:0] {
        PWRUP    = 3'd0,
        WR1      = 3'd1,
        WR2      = 3'd2,
        WR3      = 3'd3,
        WAIT_INT = 3'd4,
        RD_L     = 3'd5,
        RD_H     = 3'd6
    } state_t;

    localparam logic [15:0] CMD_CFG0 = 16'h0D02;
    localparam logic [15:0] CMD_CFG1 = 16'h1160;
    localparam logic [15:0] CMD_CFG2 = 16'h1440;
    localparam logic [15:0] CMD_RD_L = 16'hA600;
    localparam logic [15:0] CMD_RD_H = 16'hA700;

endpackage

// File: rtl/inert_reader.sv
// rtl/inert_reader.sv - configures the inertial sensor over SPI, then reads yaw rate on each data-ready
module inert_reader
    import inert_pkg::*;
#(
    parameter int PWRUP_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] yaw_rt,
    output logic        vld
);

    state_t               state_q, state_d;
    logic [PWRUP_W-1:0]   timer_q, timer_d;
    logic [7:0]           yaw_l_q, yaw_l_d;
    logic [15:0]          yaw_rt_q, yaw_rt_d;
    logic [15:0]          cmd_q, cmd_d;
    logic                 wrt_q, wrt_d;
    logic                 vld_q, vld_d;
    logic                 int_ff1_q, int_ff2_q;
    logic                 done_ff_q;
    logic                 done_rise;
    logic                 unused_rd_hi;

    // Only the low byte carries the register value.
    assign unused_rd_hi = &rd_data[15:8];

    // Edge, not level: a done held high must not walk the FSM through several states.
    assign done_rise = done & ~done_ff_q;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        yaw_l_d  = yaw_l_q;
        yaw_rt_d = yaw_rt_q;
        cmd_d    = cmd_q;
        wrt_d    = 1'b0;
        vld_d    = 1'b0;
        case (state_q)
            PWRUP: begin
                timer_d = timer_q + 1'b1;
                if (&timer_q) begin
                    timer_d = '0;
                    wrt_d   = 1'b1;
                    cmd_d   = CMD_CFG0;
                    state_d = WR1;
                end
            end
            WR1: if (done_rise) begin
                wrt_d   = 1'b1;
                cmd_d   = CMD_CFG1;
                state_d = WR2;
            end
            WR2: if (done_rise) begin
                wrt_d   = 1'b1;
                cmd_d   = CMD_CFG2;
                state_d = WR3;
            end
            WR3: if (done_rise) state_d = WAIT_INT;
            WAIT_INT: if (int_ff2_q) begin
                wrt_d   = 1'b1;
                cmd_d   = CMD_RD_L;
                state_d = RD_L;
            end
            RD_L: if (done_rise) begin
                yaw_l_d = rd_data[7:0];
                wrt_d   = 1'b1;
                cmd_d   = CMD_RD_H;
                state_d = RD_H;
            end
            RD_H: if (done_rise) begin
                yaw_rt_d = {rd_data[7:0], yaw_l_q};
                vld_d    = 1'b1;
                state_d  = WAIT_INT;
            end
            default: state_d = PWRUP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PWRUP;
            timer_q   <= '0;
            yaw_l_q   <= 8'h00;
            yaw_rt_q  <= 16'h0000;
            cmd_q     <= 16'h0000;
            wrt_q     <= 1'b0;
            vld_q     <= 1'b0;
            int_ff1_q <= 1'b0;
            int_ff2_q <= 1'b0;
            done_ff_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            yaw_l_q   <= yaw_l_d;
            yaw_rt_q  <= yaw_rt_d;
            cmd_q     <= cmd_d;
            wrt_q     <= wrt_d;
            vld_q     <= vld_d;
            int_ff1_q <= INT;
            int_ff2_q <= int_ff1_q;
            done_ff_q <= done;
        end
    end

    assign wrt    = wrt_q;
    assign cmd    = cmd_q;
    assign yaw_rt = yaw_rt_q;
    assign vld    = vld_q;

endmodule
